// File: rtl/mpeg_feeder_pkg.sv
// rtl/mpeg_feeder_pkg.sv - shared types and defaults for the MPEG stream feeder
package mpeg_feeder_pkg;

  localparam int ADDR_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - first-word-fall-through byte FIFO with synchronous clear
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sys_clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_wr && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mpeg_stream_feeder.sv
// rtl/mpeg_stream_feeder.sv - fetches the elementary stream from memory and feeds the decoder
module mpeg_stream_feeder
  import mpeg_feeder_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEFAULT,
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] stream_length,
  input  logic              seek_req,
  input  logic [ADDR_W-1:0] seek_addr,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [7:0]        mem_rd_data,
  input  logic              busy,
  output logic [7:0]        stream_data,
  output logic              stream_valid,
  output logic [ADDR_W-1:0] stream_byte_index,
  output logic              seek_busy,
  output logic              eos
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = CNT_W + 1;

  feeder_state_t     state;
  feeder_state_t     state_next;
  logic [OUT_W-1:0]  outstanding;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] pending_addr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [7:0]        fifo_rd_data;
  logic [SUM_W-1:0]  inflight;
  logic              accept;
  logic              pop;
  logic              fifo_wr;
  logic              flush_done;

  // Counting in-flight reads against free FIFO space guarantees every return has a slot.
  assign inflight   = SUM_W'(outstanding) + SUM_W'(fifo_count);
  assign mem_rd_req = !rst && !seek_req && (state == RUN)
                      && (fetch_addr < stream_length)
                      && (outstanding < OUT_W'(MAX_OUTSTANDING))
                      && (inflight < SUM_W'(FIFO_DEPTH));
  assign mem_rd_addr = fetch_addr;
  assign accept      = mem_rd_req && mem_rd_ack;
  assign pop         = (state == RUN) && !seek_req && !busy && !fifo_empty;
  assign fifo_wr     = (state == RUN) && mem_rd_valid && !fifo_full;
  assign flush_done  = (state == FLUSH) && !seek_req && (outstanding == '0);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst     (rst),
    .clear   (seek_req),
    .wr_en   (fifo_wr),
    .wr_data (mem_rd_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (seek_req) begin
      state_next = FLUSH;
    end else begin
      case (state)
        RUN: begin
          if ((fetch_addr == stream_length) && (outstanding == '0) && fifo_empty)
            state_next = DONE;
        end
        FLUSH: begin
          if (outstanding == '0)
            state_next = (pending_addr < stream_length) ? RUN : DONE;
        end
        DONE:    ;
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      outstanding       <= '0;
      fetch_addr        <= '0;
      pending_addr      <= '0;
      stream_byte_index <= '0;
      stream_valid      <= 1'b0;
      stream_data       <= 8'h00;
      seek_busy         <= 1'b0;
      eos               <= 1'b0;
    end else begin
      case ({accept, mem_rd_valid})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: ;
      endcase

      if (seek_req) pending_addr <= seek_addr;

      if (flush_done)  fetch_addr <= pending_addr;
      else if (accept) fetch_addr <= fetch_addr + ADDR_W'(1);

      if (flush_done) stream_byte_index <= pending_addr;
      else if (pop)   stream_byte_index <= stream_byte_index + ADDR_W'(1);

      stream_valid <= pop;
      stream_data  <= pop ? fifo_rd_data : 8'h00;
      seek_busy    <= (state_next == FLUSH);
      eos          <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_mpeg_stream_feeder.sv
// tb/tb_mpeg_stream_feeder.sv - directed self-checking bench for mpeg_stream_feeder
module tb_mpeg_stream_feeder;

  localparam int AW = 32;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] stream_length = '0;
  logic          seek_req = 1'b0;
  logic [AW-1:0] seek_addr = '0;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_ack = 1'b0;
  logic          mem_rd_valid = 1'b0;
  logic [7:0]    mem_rd_data = 8'h00;
  logic          busy = 1'b0;
  logic [7:0]    stream_data;
  logic          stream_valid;
  logic [AW-1:0] stream_byte_index;
  logic          seek_busy;
  logic          eos;

  mpeg_stream_feeder dut (
    .sys_clk           (sys_clk),
    .rst               (rst),
    .stream_length     (stream_length),
    .seek_req          (seek_req),
    .seek_addr         (seek_addr),
    .mem_rd_req        (mem_rd_req),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_ack        (mem_rd_ack),
    .mem_rd_valid      (mem_rd_valid),
    .mem_rd_data       (mem_rd_data),
    .busy              (busy),
    .stream_data       (stream_data),
    .stream_valid      (stream_valid),
    .stream_byte_index (stream_byte_index),
    .seek_busy         (seek_busy),
    .eos               (eos)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } rd_t;

  rd_t        q[$];
  logic [7:0] got[$];
  int  cyc = 0;
  int  lat = 3;
  bit  ack_alt = 1'b0;
  bit  track = 1'b0;
  int  acc_cnt = 0;
  int  pres_cnt = 0;
  int  bad_req = 0;
  int  flush_returns = 0;
  int  first_vcyc = 0;
  int  last_vcyc = 0;
  int  max_inflight = 0;
  int  cur_inflight = 0;
  int  passed = 0;
  int  total = 0;

  // Memory model: byte at address a is a[7:0]; returns in order after lat edges.
  always @(posedge sys_clk) begin
    if (rst) begin
      q.delete();
      got.delete();
      acc_cnt       = 0;
      pres_cnt      = 0;
      bad_req       = 0;
      flush_returns = 0;
    end else begin
      if (stream_valid) begin
        if (got.size() == 0) first_vcyc = cyc;
        last_vcyc = cyc;
        got.push_back(stream_data);
        pres_cnt++;
      end
      if (mem_rd_valid) begin
        if (seek_busy) flush_returns++;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (mem_rd_req && (mem_rd_addr >= stream_length)) bad_req++;
      if (mem_rd_req && mem_rd_ack) begin
        q.push_back('{due: cyc + lat, addr: mem_rd_addr});
        acc_cnt++;
      end
    end
    cyc++;
  end

  always @(negedge sys_clk) begin
    mem_rd_ack = ack_alt ? cyc[0] : 1'b1;
    if (q.size() > 0 && q[0].due <= cyc) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = q[0].addr[7:0];
    end else begin
      mem_rd_valid = 1'b0;
      mem_rd_data  = 8'h00;
    end
    if (track) begin
      cur_inflight = acc_cnt - pres_cnt - int'(stream_valid);
      if (cur_inflight > max_inflight) max_inflight = cur_inflight;
    end else begin
      max_inflight = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return stream_valid;
      1:       return eos;
      2:       return !seek_busy;
      default: return (q.size() == 4);
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, input string tag);
    int n = 0;
    while (n < limit && !cond(which)) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, 64'(n < limit), 64'd1);
  endtask

  function automatic logic [7:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  initial begin
    int errs;
    int vhigh;
    int reqs;
    int n0;

    // Reset state
    rst = 1'b1;
    stream_length = 32'd16;
    tick(2);
    check("rst_valid", 64'(stream_valid), 64'd0);
    check("rst_data", 64'(stream_data), 64'd0);
    check("rst_index", 64'(stream_byte_index), 64'd0);
    check("rst_req", 64'(mem_rd_req), 64'd0);
    check("rst_addr", 64'(mem_rd_addr), 64'd0);
    check("rst_seek_busy", 64'(seek_busy), 64'd0);
    check("rst_eos", 64'(eos), 64'd0);

    // 16-byte stream, latency 3, no backpressure
    rst = 1'b0;
    wait_for(1, 300, "p1_eos_timeout");
    for (int i = 0; i < 16; i++) check("p1_byte", 64'(got_at(i)), 64'(i));
    check("p1_count", 64'(got.size()), 64'd16);
    check("p1_span", 64'(last_vcyc - first_vcyc), 64'd15);
    check("p1_index", 64'(stream_byte_index), 64'd16);
    check("p1_done_req", 64'(mem_rd_req), 64'd0);

    // Backpressure for 10 cycles mid-stream
    rst = 1'b1;
    stream_length = 32'd40;
    tick(1);
    rst = 1'b0;
    track = 1'b1;
    tick(12);
    busy = 1'b1;
    vhigh = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (stream_valid) vhigh++;
    end
    busy = 1'b0;
    check("p2_busy_valid", 64'(vhigh), 64'd0);
    wait_for(1, 300, "p2_eos_timeout");
    check("p2_max_inflight", 64'(max_inflight), 64'd8);
    track = 1'b0;
    errs = 0;
    for (int i = 0; i < 40; i++) if (got_at(i) !== 8'(i)) errs++;
    check("p2_order_errs", 64'(errs), 64'd0);
    check("p2_count", 64'(got.size()), 64'd40);

    // Ack withheld every other cycle, 100 bytes
    rst = 1'b1;
    stream_length = 32'd100;
    ack_alt = 1'b1;
    tick(1);
    rst = 1'b0;
    wait_for(1, 1000, "p3_eos_timeout");
    errs = 0;
    for (int i = 0; i < 100; i++) if (got_at(i) !== 8'(i)) errs++;
    check("p3_order_errs", 64'(errs), 64'd0);
    check("p3_count", 64'(got.size()), 64'd100);
    check("p3_bad_req", 64'(bad_req), 64'd0);
    check("p3_index", 64'(stream_byte_index), 64'd100);

    // Seek to 0x40 with 4 reads outstanding
    rst = 1'b1;
    stream_length = 32'd200;
    ack_alt = 1'b0;
    lat = 6;
    tick(1);
    rst = 1'b0;
    wait_for(3, 20, "p4_outstanding_timeout");
    seek_req = 1'b1;
    seek_addr = 32'h40;
    tick(1);
    seek_req = 1'b0;
    check("p4_seek_busy", 64'(seek_busy), 64'd1);
    check("p4_valid_low", 64'(stream_valid), 64'd0);
    wait_for(2, 40, "p4_flush_timeout");
    check("p4_dropped", 64'(flush_returns), 64'd4);
    check("p4_mem_idle", 64'(q.size()), 64'd0);
    check("p4_index", 64'(stream_byte_index), 64'h40);
    wait_for(0, 40, "p4_valid_timeout");
    check("p4_first_data", 64'(stream_data), 64'h40);
    tick(1);
    check("p4_first_got", 64'(got_at(0)), 64'h40);

    // Two seeks two cycles apart: last one wins
    tick(5);
    seek_req = 1'b1;
    seek_addr = 32'h10;
    tick(1);
    seek_req = 1'b0;
    tick(1);
    seek_req = 1'b1;
    seek_addr = 32'h80;
    tick(1);
    seek_req = 1'b0;
    wait_for(2, 40, "p5_flush_timeout");
    check("p5_index", 64'(stream_byte_index), 64'h80);
    n0 = got.size();
    wait_for(0, 40, "p5_valid_timeout");
    check("p5_data", 64'(stream_data), 64'h80);
    check("p5_index_after", 64'(stream_byte_index), 64'h81);
    tick(1);
    check("p5_got", 64'(got_at(n0)), 64'h80);

    // Seek to stream_length, then back to 5
    seek_req = 1'b1;
    seek_addr = 32'd200;
    tick(1);
    seek_req = 1'b0;
    wait_for(2, 40, "p6_flush_timeout");
    check("p6_eos", 64'(eos), 64'd1);
    check("p6_index", 64'(stream_byte_index), 64'd200);
    reqs = 0;
    vhigh = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (mem_rd_req) reqs++;
      if (stream_valid) vhigh++;
    end
    check("p6_no_req", 64'(reqs), 64'd0);
    check("p6_no_valid", 64'(vhigh), 64'd0);
    seek_req = 1'b1;
    seek_addr = 32'd5;
    tick(1);
    seek_req = 1'b0;
    check("p6_eos_clear", 64'(eos), 64'd0);
    wait_for(0, 40, "p6_valid_timeout");
    check("p6_resume_data", 64'(stream_data), 64'd5);

    // Reset mid-stream
    tick(8);
    rst = 1'b1;
    tick(1);
    check("p7_valid", 64'(stream_valid), 64'd0);
    check("p7_data", 64'(stream_data), 64'd0);
    check("p7_index", 64'(stream_byte_index), 64'd0);
    check("p7_req", 64'(mem_rd_req), 64'd0);
    check("p7_addr", 64'(mem_rd_addr), 64'd0);
    check("p7_seek_busy", 64'(seek_busy), 64'd0);
    check("p7_eos", 64'(eos), 64'd0);
    rst = 1'b0;
    wait_for(0, 40, "p7_valid_timeout");
    check("p7_restart_data", 64'(stream_data), 64'd0);
    check("p7_restart_index", 64'(stream_byte_index), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
